// File: rtl/adc_scan_scheduler.sv
// ADC conversion scheduler: arbitrates a continuous channel scan against
// one-shot requests and runs one conversion at a time on the frame engine.
module adc_scan_scheduler #(
    parameter logic [7:0]  SCAN_MASK = 8'b0001_1010,
    parameter int unsigned TIMEOUT   = 32
) (
    input  logic        adc_sck,
    input  logic        rst,
    input  logic        scan_en,
    input  logic        oneshot_req,
    input  logic [2:0]  oneshot_ch,
    output logic        oneshot_ack,
    output logic        oneshot_valid,
    output logic [11:0] oneshot_data,
    output logic        scan_valid,
    output logic [2:0]  scan_ch,
    output logic [11:0] scan_data,
    output logic        frame_done,
    output logic        conv_start,
    output logic [2:0]  conv_ch,
    input  logic        conv_done,
    input  logic [11:0] conv_data,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    function automatic logic [2:0] next_set(input logic [2:0] p);
        logic [2:0] r;
        logic [2:0] c;
        logic       hit;
        r   = p;
        hit = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            c = p + 3'(i);
            if (!hit && SCAN_MASK[c]) begin
                r   = c;
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] top_set();
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (SCAN_MASK[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Searching forward from 7 lands on the lowest set bit.
    localparam logic [2:0] PTR_RST  = next_set(3'd7);
    localparam logic [2:0] PTR_TOP  = top_set();
    localparam bit         HAS_SCAN = |SCAN_MASK;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]  ptr_q;
    logic        last_scan_q;
    logic        cur_os_q;
    logic        conv_start_q;
    logic [2:0]  conv_ch_q;
    logic        oneshot_ack_q;
    logic        oneshot_valid_q;
    logic [11:0] oneshot_data_q;
    logic        scan_valid_q;
    logic [2:0]  scan_ch_q;
    logic [11:0] scan_data_q;
    logic        frame_done_q;
    logic        timeout_err_q;

    logic scan_elig;
    logic grant_os;

    assign scan_elig = scan_en && HAS_SCAN;
    // The one-shot wins only when scan went last or scan has nothing to offer.
    assign grant_os  = oneshot_req && (last_scan_q || !scan_elig);

    always_ff @(posedge adc_sck) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            ptr_q           <= PTR_RST;
            last_scan_q     <= 1'b0;
            cur_os_q        <= 1'b0;
            conv_start_q    <= 1'b0;
            conv_ch_q       <= '0;
            oneshot_ack_q   <= 1'b0;
            oneshot_valid_q <= 1'b0;
            oneshot_data_q  <= '0;
            scan_valid_q    <= 1'b0;
            scan_ch_q       <= '0;
            scan_data_q     <= '0;
            frame_done_q    <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            conv_start_q    <= 1'b0;
            oneshot_ack_q   <= 1'b0;
            oneshot_valid_q <= 1'b0;
            scan_valid_q    <= 1'b0;
            frame_done_q    <= 1'b0;
            timeout_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_os) begin
                        state_q       <= ISSUE;
                        cur_os_q      <= 1'b1;
                        last_scan_q   <= 1'b0;
                        conv_ch_q     <= oneshot_ch;
                        conv_start_q  <= 1'b1;
                        oneshot_ack_q <= 1'b1;
                    end else if (scan_elig) begin
                        state_q      <= ISSUE;
                        cur_os_q     <= 1'b0;
                        last_scan_q  <= 1'b1;
                        conv_ch_q    <= ptr_q;
                        conv_start_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                WAIT: begin
                    if (conv_done) begin
                        state_q <= IDLE;
                        if (cur_os_q) begin
                            oneshot_valid_q <= 1'b1;
                            oneshot_data_q  <= conv_data;
                        end else begin
                            scan_valid_q <= 1'b1;
                            scan_ch_q    <= conv_ch_q;
                            scan_data_q  <= conv_data;
                            frame_done_q <= (conv_ch_q == PTR_TOP);
                            ptr_q        <= next_set(ptr_q);
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q       <= IDLE;
                        timeout_err_q <= 1'b1;
                        if (cur_os_q) begin
                            oneshot_valid_q <= 1'b1;
                            oneshot_data_q  <= '0;
                        end else begin
                            frame_done_q <= (conv_ch_q == PTR_TOP);
                            ptr_q        <= next_set(ptr_q);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oneshot_ack   = oneshot_ack_q;
    assign oneshot_valid = oneshot_valid_q;
    assign oneshot_data  = oneshot_data_q;
    assign scan_valid    = scan_valid_q;
    assign scan_ch       = scan_ch_q;
    assign scan_data     = scan_data_q;
    assign frame_done    = frame_done_q;
    assign conv_start    = conv_start_q;
    assign conv_ch       = conv_ch_q;
    assign timeout_err   = timeout_err_q;

endmodule
